// File: rtl/ahb_slave_pkt_buf.sv
//------------------------------------------------------------------------------
// ahb_slave_pkt_buf
//
// AHB-Lite slave front-end for the AHB-to-APB bridge. Accepts single AHB
// transfers, turns them into {write, data, addr} packets for the bridge and
// returns read data. Writes pass through a small FIFO. Reads wait until that
// FIFO has drained, so the bridge sees packets in bus order.
//
// Build option:
//   AHB_SLV_WRITE_POST_EN  defined   : posted writes. A write completes with
//                                      zero wait states while the FIFO has
//                                      room. A bridge error on a write sets
//                                      the sticky Wr_Err flag.
//                          undefined : non-posted writes. Each write holds
//                                      HREADYOUT low until its own packet has
//                                      been taken. A bridge error gives a
//                                      two-cycle AHB ERROR response.
//
// Parameters:
//   ADDR_W      address width (HADDR, packet addr field)
//   DATA_W      data width (HWDATA/HRDATA, packet data field)
//   WBUF_DEPTH  write FIFO entries, power of 2, >= 2
//
// Ports:
//   HCLK, RESET         clock, synchronous active-high reset
//   HSEL, HADDR, HWRITE, HTRANS, HREADY   AHB address phase
//   HWDATA              AHB write data (data phase)
//   HRDATA, HREADYOUT, HRESP              AHB slave response
//   Packet_Out, H_Valid, Bridge_Ready     packet handshake to the bridge
//   Bridge_Rd_Data, Bridge_Rd_Valid       read return from the bridge
//   Bridge_Err          bridge error qualifier
//   Wr_Err              sticky posted-write error
//   dbg_state           current FSM state encoding
//
// Packet handshake: Packet_Out is meaningful while H_Valid is high. A
// transfer happens on any rising edge where H_Valid && Bridge_Ready. While
// H_Valid is high and Bridge_Ready is low, Packet_Out and H_Valid hold steady.
//------------------------------------------------------------------------------
module ahb_slave_pkt_buf #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                   HCLK,
    input  logic                   RESET,
    input  logic                   HSEL,
    input  logic [ADDR_W-1:0]      HADDR,
    input  logic                   HWRITE,
    input  logic [1:0]             HTRANS,
    input  logic                   HREADY,
    input  logic [DATA_W-1:0]      HWDATA,
    output logic [DATA_W-1:0]      HRDATA,
    output logic                   HREADYOUT,
    output logic                   HRESP,
    output logic [DATA_W+ADDR_W:0] Packet_Out,
    output logic                   H_Valid,
    input  logic                   Bridge_Ready,
    input  logic [DATA_W-1:0]      Bridge_Rd_Data,
    input  logic                   Bridge_Rd_Valid,
    input  logic                   Bridge_Err,
    output logic                   Wr_Err,
    output logic [2:0]             dbg_state
);

    localparam int PKT_W = 1 + DATA_W + ADDR_W;
    localparam int PTR_W = $clog2(WBUF_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WDATA    = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_ERR1     = 3'd4,
        ST_ERR2     = 3'd5
    } state_t;

    state_t             state;
    state_t             nxt_accept;
    logic [ADDR_W-1:0]  addr_reg;
    logic [PKT_W-1:0]   fifo_mem [WBUF_DEPTH];
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               rd_vld;     // read request packet on Packet_Out
    logic               hready_int;
    logic               accept;
    logic               unused_htrans0;
`ifndef AHB_SLV_WRITE_POST_EN
    logic               wr_sent;    // this write's packet is already queued
`endif

    // SEQ vs NONSEQ makes no difference to a single-transfer slave.
    assign unused_htrans0 = HTRANS[0];

    // Pointers carry one extra wrap bit: equal means empty, equal except
    // the wrap bit means full.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // rd_vld is only set while the FIFO is empty, so the two packet sources
    // never compete for the output.
    assign pop        = !fifo_empty && Bridge_Ready;
    assign H_Valid    = !fifo_empty || rd_vld;
    assign Packet_Out = rd_vld     ? {1'b0, {DATA_W{1'b0}}, addr_reg} :
                        fifo_empty ? '0 : fifo_mem[rd_ptr[PTR_W-1:0]];

`ifdef AHB_SLV_WRITE_POST_EN
    // A full FIFO can still take the write in a cycle where the head leaves.
    assign push = (state == ST_WDATA) && (!fifo_full || pop);
`else
    assign push = (state == ST_WDATA) && !wr_sent && !fifo_full;
`endif

    always_comb begin
        hready_int = 1'b1;
        case (state)
`ifdef AHB_SLV_WRITE_POST_EN
            ST_WDATA:    hready_int = !fifo_full || pop;
`else
            ST_WDATA:    hready_int = 1'b0;
`endif
            ST_RD_ISSUE: hready_int = 1'b0;
            ST_RD_WAIT:  hready_int = 1'b0;
            ST_ERR1:     hready_int = 1'b0;
            default:     hready_int = 1'b1;
        endcase
    end

    assign HREADYOUT = hready_int;
    assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
    assign dbg_state = state;

    assign accept = HSEL && HTRANS[1] && HREADY && hready_int;

    // Next state for any cycle that closes a data phase with HREADYOUT=1.
    always_comb begin
        nxt_accept = ST_IDLE;
        if (accept) begin
            nxt_accept = HWRITE ? ST_WDATA : ST_RD_ISSUE;
        end
    end

    // FIFO storage. It is not reset because the pointers define its content.
    always_ff @(posedge HCLK) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= {1'b1, HWDATA, addr_reg};
        end
    end

    always_ff @(posedge HCLK) begin
        if (RESET) begin
            state    <= ST_IDLE;
            addr_reg <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_vld   <= 1'b0;
            HRDATA   <= '0;
`ifdef AHB_SLV_WRITE_POST_EN
            Wr_Err   <= 1'b0;
`else
            wr_sent  <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept) begin
                addr_reg <= HADDR;
            end
`ifdef AHB_SLV_WRITE_POST_EN
            // Every FIFO entry is a write, so a pop is a write handshake.
            if (pop && Bridge_Err) begin
                Wr_Err <= 1'b1;
            end
`endif

            case (state)
                ST_IDLE: begin
                    state <= nxt_accept;
                end

                ST_WDATA: begin
`ifdef AHB_SLV_WRITE_POST_EN
                    if (hready_int) begin
                        state <= nxt_accept;
                    end
`else
                    if (!wr_sent) begin
                        if (push) begin
                            wr_sent <= 1'b1;
                        end
                    end else if (pop) begin
                        wr_sent <= 1'b0;
                        state   <= Bridge_Err ? ST_ERR1 : ST_IDLE;
                    end
`endif
                end

                ST_RD_ISSUE: begin
                    if (!rd_vld) begin
                        // Older writes must leave first.
                        if (fifo_empty) begin
                            rd_vld <= 1'b1;
                        end
                    end else if (Bridge_Ready) begin
                        rd_vld <= 1'b0;
                        state  <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    if (Bridge_Rd_Valid) begin
                        if (Bridge_Err) begin
                            state <= ST_ERR1;
                        end else begin
                            HRDATA <= Bridge_Rd_Data;
                            state  <= ST_IDLE;
                        end
                    end
                end

                ST_ERR1: begin
                    state <= ST_ERR2;
                end

                ST_ERR2: begin
                    state <= nxt_accept;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef AHB_SLV_WRITE_POST_EN
    assign Wr_Err = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_slave_pkt_buf.sv
//------------------------------------------------------------------------------
// tb_ahb_slave_pkt_buf
//
// Directed bench for ahb_slave_pkt_buf with the default parameters
// (ADDR_W=8, DATA_W=32, WBUF_DEPTH=4). It covers both builds of
// AHB_SLV_WRITE_POST_EN. Inputs change 1 ns after the rising edge, and
// outputs are sampled 1-2 ns later. Packets taken by the bridge are checked
// against exp_q at the falling edge.
//------------------------------------------------------------------------------
module tb_ahb_slave_pkt_buf;

`ifdef AHB_SLV_WRITE_POST_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WDATA    = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_WAIT  = 3'd3;

    logic        HCLK;
    logic        RESET;
    logic        HSEL;
    logic [7:0]  HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [40:0] Packet_Out;
    logic        H_Valid;
    logic        Bridge_Ready;
    logic [31:0] Bridge_Rd_Data;
    logic        Bridge_Rd_Valid;
    logic        Bridge_Err;
    logic        Wr_Err;
    logic [2:0]  dbg_state;

    int          n_vec = 0;
    int          n_err = 0;
    logic [40:0] exp_q[$];
    logic [40:0] mon_exp;

    // Single-slave system: the bus HREADY is this slave's HREADYOUT.
    assign HREADY = HREADYOUT;

    ahb_slave_pkt_buf dut (
        .HCLK            (HCLK),
        .RESET           (RESET),
        .HSEL            (HSEL),
        .HADDR           (HADDR),
        .HWRITE          (HWRITE),
        .HTRANS          (HTRANS),
        .HREADY          (HREADY),
        .HWDATA          (HWDATA),
        .HRDATA          (HRDATA),
        .HREADYOUT       (HREADYOUT),
        .HRESP           (HRESP),
        .Packet_Out      (Packet_Out),
        .H_Valid         (H_Valid),
        .Bridge_Ready    (Bridge_Ready),
        .Bridge_Rd_Data  (Bridge_Rd_Data),
        .Bridge_Rd_Valid (Bridge_Rd_Valid),
        .Bridge_Err      (Bridge_Err),
        .Wr_Err          (Wr_Err),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    // ---------------- helpers / driver tasks ----------------
    function automatic logic [40:0] pkt(input logic w, input logic [31:0] d,
                                        input logic [7:0] a);
        return {w, d, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task step();
        @(posedge HCLK);
        #1;
    endtask

    task bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = 8'h00;
    endtask

    task addr_ph(input logic w, input logic [7:0] a);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = w;
        HADDR  = a;
    endtask

    // ---------------- scoreboard: packets taken by the bridge ----------------
    always @(negedge HCLK) begin
        if (!RESET && H_Valid && Bridge_Ready) begin
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL pkt_unexpected: observed %0h expected none", Packet_Out);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                n_vec++;
                assert (Packet_Out === mon_exp) else begin
                    n_err++;
                    $error("FAIL pkt_order: observed %0h expected %0h", Packet_Out, mon_exp);
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        RESET           = 1'b1;
        bus_idle();
        HWDATA          = 32'h0;
        Bridge_Ready    = 1'b0;
        Bridge_Rd_Data  = 32'h0;
        Bridge_Rd_Valid = 1'b0;
        Bridge_Err      = 1'b0;
        repeat (3) step();
        RESET = 1'b0;
        #1;
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_hreadyout", HREADYOUT, 1);
        chk("rst_hresp", HRESP, 0);
        chk("rst_packet", Packet_Out, 0);
        chk("rst_hvalid", H_Valid, 0);
        chk("rst_wr_err", Wr_Err, 0);
        chk("rst_state", dbg_state, S_IDLE);

        // ---- single write 0x10 / 0xA0, bridge stalls one cycle ----
        addr_ph(1'b1, 8'h10);
        #1 chk("wr_addr_hready", HREADYOUT, 1);
        step();
        bus_idle();
        HWDATA = 32'h0000_00A0;
        exp_q.push_back(pkt(1'b1, 32'hA0, 8'h10));
        #1 chk("wr_data_hready", HREADYOUT, POSTED ? 1 : 0);
        chk("wr_data_state", dbg_state, S_WDATA);
        chk("wr_hvalid_late", H_Valid, 0);
        step();
        #1 chk("wr_hvalid", H_Valid, 1);
        chk("wr_packet", Packet_Out, pkt(1'b1, 32'hA0, 8'h10));
        chk("wr_state2", dbg_state, POSTED ? S_IDLE : S_WDATA);
        step();
        #1 chk("wr_packet_stable", Packet_Out, pkt(1'b1, 32'hA0, 8'h10));
        chk("wr_hvalid_stable", H_Valid, 1);
        Bridge_Ready = 1'b1;
        #1 chk("wr_hready_at_pop", HREADYOUT, POSTED ? 1 : 0);
        step();
        Bridge_Ready = 1'b0;
        #1 chk("wr_done_hready", HREADYOUT, 1);
        chk("wr_done_hvalid", H_Valid, 0);
        chk("wr_done_hresp", HRESP, 0);

        // ---- write 0x11 / 0xA1 that the bridge flags as an error ----
        addr_ph(1'b1, 8'h11);
        step();
        bus_idle();
        HWDATA       = 32'h0000_00A1;
        Bridge_Ready = 1'b1;
        Bridge_Err   = 1'b1;
        exp_q.push_back(pkt(1'b1, 32'hA1, 8'h11));
        #1 chk("werr_data_hready", HREADYOUT, POSTED ? 1 : 0);
        step();
        #1 chk("werr_hvalid", H_Valid, 1);
        step();
        Bridge_Ready = 1'b0;
        Bridge_Err   = 1'b0;
        #1;
`ifdef AHB_SLV_WRITE_POST_EN
        chk("werr_sticky_set", Wr_Err, 1);
        chk("werr_no_bus_err", HRESP, 0);
        chk("werr_state", dbg_state, S_IDLE);
`else
        chk("werr_err1_hresp", HRESP, 1);
        chk("werr_err1_hready", HREADYOUT, 0);
        step();
        #1 chk("werr_err2_hresp", HRESP, 1);
        chk("werr_err2_hready", HREADYOUT, 1);
        chk("werr_tied_low", Wr_Err, 0);
`endif

        // ---- read 0x20, offered in ERR2 (non-posted) or IDLE (posted) ----
        addr_ph(1'b0, 8'h20);
        #1 chk("rd_accept_hready", HREADYOUT, 1);
        step();
        bus_idle();
        Bridge_Rd_Valid = 1'b1;  // stray return, must be ignored
        Bridge_Rd_Data  = 32'h1234_5678;
        #1 chk("rd_issue_state", dbg_state, S_RD_ISSUE);
        chk("rd_issue_hready", HREADYOUT, 0);
        chk("rd_issue_hvalid", H_Valid, 0);
        step();
        Bridge_Rd_Valid = 1'b0;
        exp_q.push_back(pkt(1'b0, 32'h0, 8'h20));
        #1 chk("rd_hvalid", H_Valid, 1);
        chk("rd_packet", Packet_Out, pkt(1'b0, 32'h0, 8'h20));
        chk("rd_stray_ignored", HRDATA, 0);
        chk("rd_still_issue", dbg_state, S_RD_ISSUE);
        step();
        #1 chk("rd_packet_stable", Packet_Out, pkt(1'b0, 32'h0, 8'h20));
        Bridge_Ready = 1'b1;
        step();
        Bridge_Ready = 1'b0;
        #1 chk("rd_wait_state", dbg_state, S_RD_WAIT);
        chk("rd_wait_hready", HREADYOUT, 0);
        chk("rd_wait_hvalid", H_Valid, 0);
        Bridge_Rd_Valid = 1'b1;
        Bridge_Rd_Data  = 32'hDEAD_BEEF;
        step();
        Bridge_Rd_Valid = 1'b0;
        Bridge_Rd_Data  = 32'h0;
        #1 chk("rd_done_hready", HREADYOUT, 1);
        chk("rd_done_hresp", HRESP, 0);
        chk("rd_done_hrdata", HRDATA, 32'hDEAD_BEEF);

        // ---- read 0x30 with bridge error ----
        addr_ph(1'b0, 8'h30);
        step();
        bus_idle();
        step();
        exp_q.push_back(pkt(1'b0, 32'h0, 8'h30));
        Bridge_Ready = 1'b1;
        step();
        Bridge_Ready    = 1'b0;
        Bridge_Rd_Valid = 1'b1;
        Bridge_Err      = 1'b1;
        Bridge_Rd_Data  = 32'h5555_5555;
        step();
        Bridge_Rd_Valid = 1'b0;
        Bridge_Err      = 1'b0;
        #1 chk("rerr_err1_hresp", HRESP, 1);
        chk("rerr_err1_hready", HREADYOUT, 0);
        step();
        #1 chk("rerr_err2_hresp", HRESP, 1);
        chk("rerr_err2_hready", HREADYOUT, 1);
        chk("rerr_hrdata_hold", HRDATA, 32'hDEAD_BEEF);
        step();
        #1 chk("rerr_okay_hresp", HRESP, 0);
        chk("rerr_okay_hready", HREADYOUT, 1);

        // ---- IDLE / BUSY / unselected transfers produce nothing ----
        HSEL   = 1'b1;
        HTRANS = 2'b00;
        HWRITE = 1'b1;
        HADDR  = 8'h50;
        #1 chk("idle_tr_hready", HREADYOUT, 1);
        step();
        HTRANS = 2'b01;
        #1 chk("idle_tr_state", dbg_state, S_IDLE);
        chk("idle_tr_hvalid", H_Valid, 0);
        chk("busy_tr_hresp", HRESP, 0);
        step();
        HSEL   = 1'b0;
        HTRANS = 2'b10;
        #1 chk("busy_tr_state", dbg_state, S_IDLE);
        step();
        bus_idle();
        #1 chk("unsel_state", dbg_state, S_IDLE);
        chk("unsel_hvalid", H_Valid, 0);

`ifdef AHB_SLV_WRITE_POST_EN
        // ---- posted burst of 5 writes into a 4-deep FIFO ----
        for (int i = 0; i < 5; i++) begin
            addr_ph(1'b1, 8'h10 + 8'(i));
            if (i > 0) begin
                HWDATA = 32'hA0 + 32'(i - 1);
                exp_q.push_back(pkt(1'b1, 32'hA0 + 32'(i - 1), 8'h10 + 8'(i - 1)));
            end
            #1 chk("burst_zero_wait", HREADYOUT, 1);
            step();
        end
        bus_idle();
        HWDATA = 32'hA4;
        exp_q.push_back(pkt(1'b1, 32'hA4, 8'h14));
        #1 chk("burst_5th_stall", HREADYOUT, 0);
        chk("burst_head", Packet_Out, pkt(1'b1, 32'hA0, 8'h10));
        step();
        #1 chk("burst_stall_hold", HREADYOUT, 0);
        Bridge_Ready = 1'b1;
        #1 chk("burst_5th_on_pop", HREADYOUT, 1);
        // Push and pop together while full: four entries must remain.
        for (int i = 0; i < 4; i++) begin
            step();
            #1 chk("burst_drain_valid", H_Valid, 1);
            chk("burst_drain_pkt", Packet_Out,
                pkt(1'b1, 32'hA1 + 32'(i), 8'h11 + 8'(i)));
        end
        step();
        #1 chk("burst_drain_empty", H_Valid, 0);
        Bridge_Ready = 1'b0;

        // ---- read 0x20 behind two posted writes ----
        addr_ph(1'b1, 8'h18);
        step();
        HWDATA = 32'hB0;
        exp_q.push_back(pkt(1'b1, 32'hB0, 8'h18));
        addr_ph(1'b1, 8'h19);
        step();
        HWDATA = 32'hB1;
        exp_q.push_back(pkt(1'b1, 32'hB1, 8'h19));
        addr_ph(1'b0, 8'h20);
        step();
        bus_idle();
        exp_q.push_back(pkt(1'b0, 32'h0, 8'h20));
        #1 chk("raw_state", dbg_state, S_RD_ISSUE);
        chk("raw_head_is_write", Packet_Out, pkt(1'b1, 32'hB0, 8'h18));
        chk("raw_hready", HREADYOUT, 0);
        Bridge_Ready = 1'b1;
        for (int k = 0; k < 20 && dbg_state != S_RD_WAIT; k++) step();
        chk("raw_reach_rd_wait", dbg_state, S_RD_WAIT);
        Bridge_Ready    = 1'b0;
        Bridge_Rd_Valid = 1'b1;
        Bridge_Rd_Data  = 32'hCAFE_F00D;
        step();
        Bridge_Rd_Valid = 1'b0;
        #1 chk("raw_hrdata", HRDATA, 32'hCAFE_F00D);
        chk("raw_hready_done", HREADYOUT, 1);
        chk("werr_sticky_hold", Wr_Err, 1);
`endif

        // ---- reset asserted for 2 cycles during RD_WAIT ----
        addr_ph(1'b0, 8'h40);
        step();
        bus_idle();
        step();
        exp_q.push_back(pkt(1'b0, 32'h0, 8'h40));
        Bridge_Ready = 1'b1;
        step();
        Bridge_Ready = 1'b0;
        #1 chk("rst2_in_rd_wait", dbg_state, S_RD_WAIT);
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
        #1 chk("rst2_hrdata", HRDATA, 0);
        chk("rst2_hreadyout", HREADYOUT, 1);
        chk("rst2_hresp", HRESP, 0);
        chk("rst2_packet", Packet_Out, 0);
        chk("rst2_hvalid", H_Valid, 0);
        chk("rst2_wr_err", Wr_Err, 0);
        chk("rst2_state", dbg_state, S_IDLE);
        step();
        #1 chk("rst2_after_hready", HREADYOUT, 1);
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_slave_pkt_buf.md
# ahb_slave_pkt_buf

Parametrised second-generation AHB slave front-end for the AHB-to-APB bridge. It accepts AHB-Lite single transfers, packs them into `{write, data, addr}` packets for the bridge over a valid/ready handshake, and returns read data. It adds three things to the previous front-end: configurable address and data width, a write-posting buffer of configurable depth, and AHB ERROR responses driven from a bridge error flag.

## Interface
- `ADDR_W`, 8, HADDR and packet address width
- `DATA_W`, 32, HWDATA/HRDATA and packet data width
- `WBUF_DEPTH`, 4, write buffer entries; power of 2, minimum 2
- `HCLK`  in  1  clock; all logic on rising edge
- `RESET`  in  1  reset; synchronous, active-high
- `HSEL`  in  1  slave select
- `HADDR`  in  ADDR_W  address-phase address
- `HWRITE`  in  1  address-phase direction
- `HTRANS`  in  2  transfer type; bit 1 set means NONSEQ/SEQ
- `HREADY`  in  1  bus ready; qualifies the address phase
- `HWDATA`  in  DATA_W  write data, data phase
- `HRDATA`  out  DATA_W  read data
- `HREADYOUT`  out  1  slave ready
- `HRESP`  out  1  0 = OKAY, 1 = ERROR
- `Packet_Out`  out  1+DATA_W+ADDR_W  `{write, data, addr}`; data field is 0 for reads
- `H_Valid`  out  1  packet valid
- `Bridge_Ready`  in  1  packet accepted
- `Bridge_Rd_Data`  in  DATA_W  read return data
- `Bridge_Rd_Valid`  in  1  read return strobe
- `Bridge_Err`  in  1  error qualifier; sampled with Bridge_Rd_Valid for reads and with the write handshake for writes
- `Wr_Err`  out  1  sticky posted-write error; cleared only by RESET

## Operation
- **Address-phase accept:** `HSEL && HTRANS[1] && HREADY && HREADYOUT`. On accept, HADDR and HWRITE are registered. IDLE and BUSY transfers get a zero-wait OKAY.
- **FSM states:** IDLE, WDATA, RD_ISSUE, RD_WAIT, ERR1, ERR2.
- **IDLE:**
  - Accepted write goes to WDATA.
  - Accepted read goes to RD_ISSUE.
- **WDATA:** push `{1, HWDATA, addr_reg}` into the write FIFO.
  - If the FIFO is full, hold HREADYOUT=0 until a pop frees a slot; push in that same cycle.
  - After the push, return to IDLE, or accept a new address phase back-to-back.
- **Output stage:** the FIFO head drives Packet_Out, with `H_Valid` = FIFO not empty. A pop occurs on `H_Valid && Bridge_Ready`.
- **RD_ISSUE:** HREADYOUT=0. Wait until the FIFO is empty, which preserves ordering. Then present `{0, 0, addr_reg}` with H_Valid=1 until Bridge_Ready, then go to RD_WAIT.
- **RD_WAIT:** HREADYOUT=0 until Bridge_Rd_Valid.
  - If Bridge_Err=0: register `HRDATA <= Bridge_Rd_Data` and go to IDLE. HREADYOUT=1 and OKAY in the following cycle.
  - If Bridge_Err=1: go to ERR1.
- **ERR1:** HRESP=1, HREADYOUT=0. Next state is ERR2.
- **ERR2:** HRESP=1, HREADYOUT=1. Next state is IDLE. Any address phase offered during ERR2 is accepted normally.
- **FIFO:** binary pointers with an extra wrap bit; full and empty are derived from the pointers. A simultaneous push and pop when full is legal, and the count is unchanged.
- **Posted write error** (Bridge_Err=1 on a write handshake): set `Wr_Err`. There is no bus response, because the write has already completed.
- **HRDATA** holds its last value between reads.

## Timing
- **Reset values:** HRDATA=0, HREADYOUT=1, HRESP=0, Packet_Out=0, H_Valid=0, Wr_Err=0, FSM=IDLE, FIFO empty.
- **RESET asserted mid-transfer:** the FIFO contents and any outstanding read are discarded.
- **Posted write, FIFO not full:**
  - zero wait states;
  - H_Valid rises in the cycle after the WDATA push.
- **Read latency:** at least 3 wait states.
  - RD_ISSUE lasts at least 1 cycle.
  - RD_WAIT lasts at least 1 cycle.
  - There is 1 registered-data cycle.
- **Packet stability:** Packet_Out and H_Valid are stable while `H_Valid && !Bridge_Ready`.
- **Bridge_Rd_Valid outside RD_WAIT** is ignored.

## Configuration
- **`AHB_SLV_WRITE_POST_EN` defined:** behaviour exactly as described above.
- **`AHB_SLV_WRITE_POST_EN` undefined (non-posted writes):**
  - WDATA holds HREADYOUT=0 until its own packet completes its handshake.
  - If Bridge_Err=1 on that handshake, go to ERR1/ERR2. Otherwise HREADYOUT=1 in the next cycle.
  - Wr_Err is tied to 0.
  - The FIFO never holds more than 1 entry.

## Test plan
- **Reset:** assert RESET for 2 cycles during RD_WAIT → all outputs at their reset values, and HREADYOUT=1 in the cycle after release.
- **Posted write burst:** with Bridge_Ready=0, issue 5 writes (addr 0x10–0x14, data 0xA0–0xA4), DEPTH=4 → writes 1–4 complete with zero wait states and the 5th stalls. Raise Bridge_Ready → packets appear in order, each `{1, 0xA0+n, 0x10+n}`, and the 5th write completes when the first pop occurs.
- **Read after writes:** 2 posted writes, then a read of 0x20 → the read packet `{0, 0, 0x20}` appears only after both write pops. Bridge_Rd_Data=0xDEADBEEF → HRDATA=0xDEADBEEF with OKAY.
- **Read error:** Bridge_Rd_Valid=1 with Bridge_Err=1 → HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1, then back to OKAY.
- **Write error:**
  - Posted build: Bridge_Err=1 on a write handshake → Wr_Err=1 and stays set.
  - Non-posted build: the same stimulus gives a 2-cycle ERROR response on the bus.
- **Full-FIFO push/pop and IDLE transfers:** push and pop in the same cycle when full → count stays 4. HTRANS=IDLE with HSEL=1 → OKAY with no packet generated.
